// File: rtl/player_draw_ctrl.sv
// Player ship sequencer: on a frame tick it claims the shared VGA port, erases the 2x4 ship,
// pulses a one-cycle move to the datapath, then redraws the ship while tracking a shadow Y.
module player_draw_ctrl #(
    parameter logic signed [6:0] Y_MIN       = 7'sd0,
    parameter logic signed [6:0] Y_MAX       = 7'sd60,
    parameter logic        [2:0] SHIP_COLOUR = 3'b010,
    parameter logic        [2:0] BG_COLOUR   = 3'b000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       draw_gnt,
    output logic       draw_req,
    output logic       add_x,
    output logic [1:0] add_y,
    output logic       y_pos_mod,
    output logic       y_neg_mod,
    output logic       plot,
    output logic [2:0] colour,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    typedef enum logic [2:0] {IDLE, REQ, ERASE, MOVE, SETTLE, DRAW, DONE} state_t;

    state_t             state, state_nxt;
    logic [2:0]         cnt;
    logic               dir_up, dir_dn;
    logic signed [6:0]  y_shadow;
    logic               first_draw;
    logic               want_up, want_dn;
    logic               scanning, last_pix;

    // Clamp at the bounds so the shadow can never wrap; both buttons cancel out.
    assign want_up  = btn_inc & ~btn_dec & (y_shadow < Y_MAX);
    assign want_dn  = btn_dec & ~btn_inc & (y_shadow > Y_MIN);
    assign scanning = (state == ERASE) || (state == DRAW);
    assign last_pix = (cnt == 3'd7) && draw_gnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_tick && (want_up || want_dn || first_draw)) state_nxt = REQ;
            REQ:     if (draw_gnt) state_nxt = first_draw ? DRAW : ERASE;
            ERASE:   if (last_pix) state_nxt = MOVE;
            MOVE:    state_nxt = SETTLE;
            SETTLE:  state_nxt = DRAW;
            DRAW:    if (last_pix) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Scan counter pauses while the grant is withheld; it wraps to 0 after pixel (1,3).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= 3'd0;
            dir_up     <= 1'b0;
            dir_dn     <= 1'b0;
            y_shadow   <= 7'sd0;
            first_draw <= 1'b1;
        end else begin
            if (scanning && draw_gnt)
                cnt <= cnt + 3'd1;
            if (state == IDLE && frame_tick) begin
                dir_up <= want_up;
                dir_dn <= want_dn;
            end
            if (state == MOVE) begin
                if (dir_up)      y_shadow <= y_shadow + 7'sd1;
                else if (dir_dn) y_shadow <= y_shadow - 7'sd1;
            end
            if (state == DONE)
                first_draw <= 1'b0;
        end
    end

    assign add_x = cnt[0];
    assign add_y = cnt[2:1];

    always_comb begin
        draw_req  = 1'b0;
        plot      = 1'b0;
        colour    = 3'b000;
        y_pos_mod = 1'b0;
        y_neg_mod = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        overrun   = frame_tick && (state != IDLE);
        case (state)
            REQ:    draw_req = 1'b1;
            ERASE: begin
                draw_req = 1'b1;
                plot     = draw_gnt;
                colour   = BG_COLOUR;
            end
            MOVE: begin
                draw_req  = 1'b1;
                y_pos_mod = dir_up;
                y_neg_mod = dir_dn & ~dir_up;
            end
            SETTLE: draw_req = 1'b1;
            DRAW: begin
                draw_req = 1'b1;
                plot     = draw_gnt;
                colour   = SHIP_COLOUR;
            end
            DONE:   done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_player_draw_ctrl.sv
// Directed bench for player_draw_ctrl: cycle-by-cycle output vectors against hand-built timelines.
module tb_player_draw_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_tick = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, draw_gnt = 1'b1;
    logic       draw_req, add_x, y_pos_mod, y_neg_mod, plot, busy, done, overrun;
    logic [1:0] add_y;
    logic [2:0] colour;
    logic [11:0] obs;

    int n_chk = 0;
    int n_err = 0;

    player_draw_ctrl dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .btn_inc(btn_inc),
        .btn_dec(btn_dec), .draw_gnt(draw_gnt), .draw_req(draw_req), .add_x(add_x),
        .add_y(add_y), .y_pos_mod(y_pos_mod), .y_neg_mod(y_neg_mod), .plot(plot),
        .colour(colour), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    assign obs = {draw_req, plot, colour, add_x, add_y, y_pos_mod, y_neg_mod, busy, done};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] mk(input logic req, input logic pl, input logic [2:0] col,
                                       input logic [2:0] k, input logic pos, input logic neg,
                                       input logic bsy, input logic dn);
        return {req, pl, col, k[0], k[2:1], pos, neg, bsy, dn};
    endfunction

    // Expected vector at cycle c after a tick at c0 with grant held high.
    function automatic logic [11:0] seq_exp(input logic go, input logic first, input logic up,
                                            input logic dn, input int c);
        if (!go || c < 1) return 12'h000;
        if (first) begin
            if (c == 1)             return mk(1, 0, 3'b000, 3'd0, 0, 0, 1, 0);
            if (c >= 2 && c <= 9)   return mk(1, 1, 3'b010, 3'(c - 2), 0, 0, 1, 0);
            if (c == 10)            return mk(0, 0, 3'b000, 3'd0, 0, 0, 1, 1);
            return 12'h000;
        end
        if (c == 1)                 return mk(1, 0, 3'b000, 3'd0, 0, 0, 1, 0);
        if (c >= 2 && c <= 9)       return mk(1, 1, 3'b000, 3'(c - 2), 0, 0, 1, 0);
        if (c == 10)                return mk(1, 0, 3'b000, 3'd0, up, dn, 1, 0);
        if (c == 11)                return mk(1, 0, 3'b000, 3'd0, 0, 0, 1, 0);
        if (c >= 12 && c <= 19)     return mk(1, 1, 3'b010, 3'(c - 12), 0, 0, 1, 0);
        if (c == 20)                return mk(0, 0, 3'b000, 3'd0, 0, 0, 1, 1);
        return 12'h000;
    endfunction

    // Starts just after a negedge; issues a tick and checks n following cycles.
    task automatic run_frame(input string tag, input logic inc, input logic dec, input logic go,
                             input logic first, input logic up, input logic dn, input int n);
        btn_inc = inc; btn_dec = dec; frame_tick = 1'b1;
        #1 check({tag, " c0 overrun"}, 32'(overrun), 32'd0);
        @(negedge clk);
        frame_tick = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        for (int c = 1; c <= n; c++) begin
            #1 check($sformatf("%s c%0d", tag, c), 32'(obs), 32'(seq_exp(go, first, up, dn, c)));
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset state
        #2 check("reset vec", 32'(obs), 32'd0);
        check("reset overrun", 32'(overrun), 32'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_frame("first_draw", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12);
        run_frame("dec_at_min", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        run_frame("inc_move", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 22);
        run_frame("both_btn", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        // Climb from 1 to Y_MAX
        for (int i = 0; i < 59; i++)
            run_frame($sformatf("climb%0d", i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 21);
        run_frame("inc_at_max", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        run_frame("dec_move", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 21);

        // Grant withheld in REQ, then mid-ERASE at pixel 3 (y 59 -> 60)
        draw_gnt = 1'b0; btn_inc = 1'b1; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0; btn_inc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 check($sformatf("req_wait%0d", i), 32'(obs), 32'(mk(1, 0, 3'b000, 3'd0, 0, 0, 1, 0)));
            @(negedge clk);
        end
        draw_gnt = 1'b1;
        #1 check("req_granted", 32'(obs), 32'(mk(1, 0, 3'b000, 3'd0, 0, 0, 1, 0)));
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                draw_gnt = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    #1 check($sformatf("erase_pause%0d", j), 32'(obs), 32'(mk(1, 0, 3'b000, 3'd3, 0, 0, 1, 0)));
                    @(negedge clk);
                end
                draw_gnt = 1'b1;
            end
            #1 check($sformatf("erase_px%0d", k), 32'(obs), 32'(mk(1, 1, 3'b000, 3'(k), 0, 0, 1, 0)));
            @(negedge clk);
        end
        for (int c = 10; c <= 22; c++) begin
            #1 check($sformatf("pause_tail c%0d", c), 32'(obs), 32'(seq_exp(1, 0, 1, 0, c)));
            @(negedge clk);
        end

        // Stray tick at ERASE pixel 4 (y 60 -> 59)
        btn_dec = 1'b1; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0; btn_dec = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            frame_tick = (c == 6);
            btn_inc    = (c == 6);
            #1 check($sformatf("ovr c%0d", c), 32'(obs), 32'(seq_exp(1, 0, 0, 1, c)));
            check($sformatf("ovr flag c%0d", c), 32'(overrun), 32'(c == 6));
            @(negedge clk);
        end
        frame_tick = 1'b0; btn_inc = 1'b0;

        // Reset during DRAW pixel 5
        btn_inc = 1'b1; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0; btn_inc = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            #1 check($sformatf("pre_rst c%0d", c), 32'(obs), 32'(seq_exp(1, 0, 1, 0, c)));
            if (c < 17) @(negedge clk);
        end
        reset_n = 1'b0;
        #1 check("async_rst vec", 32'(obs), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_frame("redraw", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12);
        run_frame("dec_after_rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
